// File: rtl/relay_link_sched.sv
// Half-duplex relay link scheduler: round-robin grant, turnaround guard and max-frame watchdog.
// Optional per-side frame statistics are built when RELAY_SCHED_STATS_EN is defined.
module relay_link_sched #(
  parameter int GUARD_CYCLES     = 16,
  parameter int MAX_FRAME_CYCLES = 4096,
  parameter int CNT_W            = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_rdr,
  input  logic       req_tag,
  input  logic       frame_end_rdr,
  input  logic       frame_end_tag,
  output logic       grant_rdr,
  output logic       grant_tag,
  output logic       link_dir,
  output logic       link_busy,
  output logic       timeout_err,
  output logic       err_sticky,
  output logic [7:0] frames_rdr,
  output logic [7:0] frames_tag
);

  typedef enum logic [1:0] {S_IDLE, S_GNT_RDR, S_GNT_TAG, S_GUARD} state_t;

  localparam logic [CNT_W-1:0] L_FRAME_LAST = CNT_W'(MAX_FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_guard_cnt;
  logic             r_last_tag;
  logic             r_grant_rdr;
  logic             r_grant_tag;
  logic             r_link_dir;
  logic             r_link_busy;
  logic             r_timeout_err;
  logic             r_err_sticky;

  logic w_granted;
  logic w_frame_end;
  logic w_watchdog;

  // Only the owning side's frame_end can release; it beats a simultaneous watchdog expiry.
  always_comb begin
    w_granted   = (r_state == S_GNT_RDR) || (r_state == S_GNT_TAG);
    w_frame_end = ((r_state == S_GNT_RDR) && frame_end_rdr) ||
                  ((r_state == S_GNT_TAG) && frame_end_tag);
    w_watchdog  = w_granted && (r_frame_cnt == L_FRAME_LAST) && !w_frame_end;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= '0;
      r_guard_cnt   <= '0;
      r_last_tag    <= 1'b1;
      r_grant_rdr   <= 1'b0;
      r_grant_tag   <= 1'b0;
      r_link_dir    <= 1'b0;
      r_link_busy   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_err_sticky  <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_frame_cnt <= '0;
          if (req_rdr && (!req_tag || r_last_tag)) begin
            r_state     <= S_GNT_RDR;
            r_grant_rdr <= 1'b1;
            r_link_dir  <= 1'b0;
            r_link_busy <= 1'b1;
          end else if (req_tag) begin
            r_state     <= S_GNT_TAG;
            r_grant_tag <= 1'b1;
            r_link_dir  <= 1'b1;
            r_link_busy <= 1'b1;
          end
        end
        S_GNT_RDR, S_GNT_TAG: begin
          if (w_frame_end || w_watchdog) begin
            r_grant_rdr   <= 1'b0;
            r_grant_tag   <= 1'b0;
            r_last_tag    <= (r_state == S_GNT_TAG);
            r_timeout_err <= w_watchdog;
            r_guard_cnt   <= '0;
            if (w_watchdog) begin
              r_err_sticky <= 1'b1;
            end
            if (GUARD_CYCLES == 0) begin
              r_state     <= S_IDLE;
              r_link_busy <= 1'b0;
            end else begin
              r_state     <= S_GUARD;
              r_link_busy <= 1'b1;
            end
          end else begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end
        end
        S_GUARD: begin
          if (r_guard_cnt == L_GUARD_LAST) begin
            r_state     <= S_IDLE;
            r_link_busy <= 1'b0;
          end else begin
            r_guard_cnt <= r_guard_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_rdr   = r_grant_rdr;
  assign grant_tag   = r_grant_tag;
  assign link_dir    = r_link_dir;
  assign link_busy   = r_link_busy;
  assign timeout_err = r_timeout_err;
  assign err_sticky  = r_err_sticky;

`ifdef RELAY_SCHED_STATS_EN
  logic [7:0] r_frames_rdr;
  logic [7:0] r_frames_tag;

  // Counts normal releases only; watchdog releases are excluded by w_frame_end.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frames_rdr <= 8'h00;
      r_frames_tag <= 8'h00;
    end else begin
      if ((r_state == S_GNT_RDR) && w_frame_end && (r_frames_rdr != 8'hFF)) begin
        r_frames_rdr <= r_frames_rdr + 8'h01;
      end
      if ((r_state == S_GNT_TAG) && w_frame_end && (r_frames_tag != 8'hFF)) begin
        r_frames_tag <= r_frames_tag + 8'h01;
      end
    end
  end

  assign frames_rdr = r_frames_rdr;
  assign frames_tag = r_frames_tag;
`else
  assign frames_rdr = 8'h00;
  assign frames_tag = 8'h00;
`endif

endmodule

// File: tb/tb_relay_link_sched.sv
// Directed scoreboard bench for relay_link_sched; frame counter expectations follow RELAY_SCHED_STATS_EN.
module tb_relay_link_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_rdr, req_tag, frame_end_rdr, frame_end_tag;
  logic       grant_rdr, grant_tag, link_dir, link_busy, timeout_err, err_sticky;
  logic [7:0] frames_rdr, frames_tag;

`ifdef RELAY_SCHED_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  relay_link_sched dut (
    .clk(clk), .reset(reset),
    .req_rdr(req_rdr), .req_tag(req_tag),
    .frame_end_rdr(frame_end_rdr), .frame_end_tag(frame_end_tag),
    .grant_rdr(grant_rdr), .grant_tag(grant_tag),
    .link_dir(link_dir), .link_busy(link_busy),
    .timeout_err(timeout_err), .err_sticky(err_sticky),
    .frames_rdr(frames_rdr), .frames_tag(frames_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_fr        = 0;
  int   m_ft        = 0;

  function automatic logic [7:0] sat(input int m);
    if (!STATS_EN) return 8'h00;
    return (m > 255) ? 8'hFF : 8'(m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Output vector: {grant_rdr, grant_tag, link_dir, link_busy, timeout_err, err_sticky}
  task automatic step(input string tag, input logic [5:0] o);
    push(tag, {10'd0, o});
    tick();
    check({10'd0, grant_rdr, grant_tag, link_dir, link_busy, timeout_err, err_sticky});
  endtask

  task automatic chk_frames(input string tag);
    push(tag, {sat(m_fr), sat(m_ft)});
    check({frames_rdr, frames_tag});
  endtask

  task automatic guard_tail(input logic dir, input logic sticky);
    for (int i = 0; i < 15; i++) step("guard_busy", {2'b00, dir, 1'b1, 1'b0, sticky});
    step("guard_end", {2'b00, dir, 1'b0, 1'b0, sticky});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_rdr = 1'b0; req_tag = 1'b0; frame_end_rdr = 1'b0; frame_end_tag = 1'b0;
    step("reset_out", 6'b000000);
    m_fr = 0; m_ft = 0;
    chk_frames("reset_frames");
    reset = 1'b1;
  endtask

  initial begin
    logic side;
    // Reset held with reader request pending
    reset = 1'b0; req_rdr = 1'b1; req_tag = 1'b0; frame_end_rdr = 1'b0; frame_end_tag = 1'b0;
    step("rst_hold0", 6'b000000);
    step("rst_hold1", 6'b000000);
    chk_frames("rst_frames");
    reset = 1'b1;
    step("first_grant", 6'b100100);
    frame_end_tag = 1'b1;
    step("fe_tag_ignored", 6'b100100);
    frame_end_tag = 1'b0; req_rdr = 1'b0;
    step("req_drop_ignored", 6'b100100);
    frame_end_rdr = 1'b1;
    step("rdr_release", 6'b000100);
    frame_end_rdr = 1'b0; m_fr++;
    chk_frames("frames_after_first");
    guard_tail(1'b0, 1'b0);

    // Both sides requesting: RDR, TAG, RDR with guard between
    do_reset();
    req_rdr = 1'b1; req_tag = 1'b1;
    for (int g = 0; g < 3; g++) begin
      side = (g % 2 == 1);
      step("rr_grant", {!side, side, side, 1'b1, 2'b00});
      for (int k = 0; k < 9; k++) step("rr_hold", {!side, side, side, 1'b1, 2'b00});
      if (side) frame_end_tag = 1'b1; else frame_end_rdr = 1'b1;
      step("rr_release", {2'b00, side, 1'b1, 2'b00});
      frame_end_rdr = 1'b0; frame_end_tag = 1'b0;
      if (side) m_ft++; else m_fr++;
      if (g == 2) begin req_rdr = 1'b0; req_tag = 1'b0; end
      guard_tail(side, 1'b0);
    end
    chk_frames("frames_after_rr");

    // Tag watchdog expiry
    req_tag = 1'b1;
    step("wd_grant", 6'b011100);
    req_tag = 1'b0;
    for (int k = 0; k < 4095; k++) step("wd_hold", 6'b011100);
    step("wd_timeout", 6'b001111);
    guard_tail(1'b1, 1'b1);
    chk_frames("frames_after_timeout");

    // frame_end on the final watchdog cycle wins
    req_rdr = 1'b1;
    step("fe_last_grant", 6'b100101);
    req_rdr = 1'b0;
    for (int k = 0; k < 4095; k++) step("fe_last_hold", 6'b100101);
    frame_end_rdr = 1'b1;
    step("fe_last_release", 6'b000101);
    frame_end_rdr = 1'b0; m_fr++;
    chk_frames("frames_after_fe_last");
    guard_tail(1'b0, 1'b1);

    // Reset in the middle of a grant clears everything
    req_tag = 1'b1;
    step("mid_grant", 6'b011101);
    req_tag = 1'b0; reset = 1'b0;
    step("mid_reset", 6'b000000);
    m_fr = 0; m_ft = 0;
    chk_frames("mid_reset_frames");
    reset = 1'b1;
    step("post_reset_idle", 6'b000000);

    // Saturation of the reader frame counter
    for (int n = 0; n < 300; n++) begin
      req_rdr = 1'b1;
      step("sat_grant", 6'b100100);
      frame_end_rdr = 1'b1;
      step("sat_release", 6'b000100);
      frame_end_rdr = 1'b0; req_rdr = 1'b0; m_fr++;
      if (n == 0 || n == 254) chk_frames("sat_frames_mid");
      guard_tail(1'b0, 1'b0);
    end
    chk_frames("sat_frames_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
